// File: rtl/program_port_pkg.sv
`default_nettype none
// ============================================================================
// Module  : program_port_pkg
// Brief   : Shared types and defaults for the program-memory port arbiter.
// Revision: 1.0
// ============================================================================
package program_port_pkg;

  localparam int MEM_LAT_DEFAULT = 1;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } id_t;

  typedef struct packed {
    logic valid;
    id_t  id;
  } rsp_tag_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter2
// Brief   : Two-way round-robin grant; last-granted advances only on a grant.
// Revision: 1.0
// ============================================================================
module rr_arbiter2
  import program_port_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic valid0,
  input  logic valid1,
  output logic gnt0,
  output logic gnt1
);

  id_t r_last;

  // Grants are suppressed while reset is asserted so no accept can slip in.
  assign gnt0 = !rst && valid0 && (!valid1 || (r_last == REQ1));
  assign gnt1 = !rst && valid1 && (!valid0 || (r_last == REQ0));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= REQ1;
    end else if (gnt0) begin
      r_last <= REQ0;
    end else if (gnt1) begin
      r_last <= REQ1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/program_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : program_port_arbiter
// Brief   : Shares one program-memory read port between fetch and load.
// Revision: 1.0
// ============================================================================
module program_port_arbiter
  import program_port_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEFAULT,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [15:0]      req0_addr,
  output logic             req0_ready,
  output logic             rsp0_valid,
  output logic [31:0]      rsp0_data,
  input  logic             req1_valid,
  input  logic [15:0]      req1_addr,
  output logic             req1_ready,
  output logic             rsp1_valid,
  output logic [31:0]      rsp1_data,
  output logic [15:0]      mem_addr,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] gnt0_count,
  output logic [CNT_W-1:0] gnt1_count
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

  logic       w_gnt0;
  logic       w_gnt1;
  logic       w_accept;
  rsp_tag_t   w_rsp_tag;
  logic [15:0]      r_mem_addr;
  logic [CNT_W-1:0] r_gnt0_count;
  logic [CNT_W-1:0] r_gnt1_count;
  rsp_tag_t         r_tag [MEM_LAT+1];

  rr_arbiter2 u_rr_arbiter2 (
    .clk    (clk),
    .rst    (rst),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .gnt0   (w_gnt0),
    .gnt1   (w_gnt1)
  );

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign w_accept   = w_gnt0 || w_gnt1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_addr   <= '0;
      r_gnt0_count <= '0;
      r_gnt1_count <= '0;
    end else begin
      if (w_accept) begin
        r_mem_addr <= w_gnt1 ? req1_addr : req0_addr;
      end
      if (w_gnt0 && (r_gnt0_count != c_CNT_MAX)) begin
        r_gnt0_count <= r_gnt0_count + CNT_W'(1);
      end
      if (w_gnt1 && (r_gnt1_count != c_CNT_MAX)) begin
        r_gnt1_count <= r_gnt1_count + CNT_W'(1);
      end
    end
  end

  // Stage k holds the tag of the request accepted k edges ago; the memory
  // returns data MEM_LAT edges after mem_addr updates, so stage MEM_LAT routes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag[0] <= '0;
    end else begin
      r_tag[0] <= '{valid: w_accept, id: (w_gnt1 ? REQ1 : REQ0)};
    end
  end

  generate
    for (genvar gi = 1; gi <= MEM_LAT; gi++) begin : g_tag_stage
      always_ff @(posedge clk) begin
        if (rst) begin
          r_tag[gi] <= '0;
        end else begin
          r_tag[gi] <= r_tag[gi-1];
        end
      end
    end
  endgenerate

  assign w_rsp_tag  = r_tag[MEM_LAT];
  assign rsp0_valid = !rst && w_rsp_tag.valid && (w_rsp_tag.id == REQ0);
  assign rsp1_valid = !rst && w_rsp_tag.valid && (w_rsp_tag.id == REQ1);
  assign rsp0_data  = rsp0_valid ? mem_rdata : 32'h0;
  assign rsp1_data  = rsp1_valid ? mem_rdata : 32'h0;

  assign mem_addr   = r_mem_addr;
  assign gnt0_count = r_gnt0_count;
  assign gnt1_count = r_gnt1_count;

endmodule
`default_nettype wire

// File: tb/tb_program_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_program_port_arbiter
// Brief   : Directed self-checking bench; three instances at MEM_LAT 1/2/3.
// Revision: 1.0
// ============================================================================
module tb_program_port_arbiter;

  logic clk;
  int   n_checks;
  int   n_errors;

  // Instance 1: MEM_LAT=1, CNT_W=16
  logic        rst1, v0_1, v1_1, rdy0_1, rdy1_1, rv0_1, rv1_1;
  logic [15:0] a0_1, a1_1, ma_1;
  logic [31:0] rd0_1, rd1_1, mr_1;
  logic [15:0] c0_1, c1_1;
  // Instance 2: MEM_LAT=2, CNT_W=4
  logic        rst2, v0_2, v1_2, rdy0_2, rdy1_2, rv0_2, rv1_2;
  logic [15:0] a0_2, a1_2, ma_2;
  logic [31:0] rd0_2, rd1_2, mr_2, m2_p0;
  logic [3:0]  c0_2, c1_2;
  // Instance 3: MEM_LAT=3, CNT_W=4
  logic        rst3, v0_3, v1_3, rdy0_3, rdy1_3, rv0_3, rv1_3;
  logic [15:0] a0_3, a1_3, ma_3;
  logic [31:0] rd0_3, rd1_3, mr_3, m3_p0, m3_p1;
  logic [3:0]  c0_3, c1_3;

  program_port_arbiter #(.MEM_LAT(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst1),
    .req0_valid(v0_1), .req0_addr(a0_1), .req0_ready(rdy0_1),
    .rsp0_valid(rv0_1), .rsp0_data(rd0_1),
    .req1_valid(v1_1), .req1_addr(a1_1), .req1_ready(rdy1_1),
    .rsp1_valid(rv1_1), .rsp1_data(rd1_1),
    .mem_addr(ma_1), .mem_rdata(mr_1), .gnt0_count(c0_1), .gnt1_count(c1_1)
  );

  program_port_arbiter #(.MEM_LAT(2), .CNT_W(4)) u_dut2 (
    .clk(clk), .rst(rst2),
    .req0_valid(v0_2), .req0_addr(a0_2), .req0_ready(rdy0_2),
    .rsp0_valid(rv0_2), .rsp0_data(rd0_2),
    .req1_valid(v1_2), .req1_addr(a1_2), .req1_ready(rdy1_2),
    .rsp1_valid(rv1_2), .rsp1_data(rd1_2),
    .mem_addr(ma_2), .mem_rdata(mr_2), .gnt0_count(c0_2), .gnt1_count(c1_2)
  );

  program_port_arbiter #(.MEM_LAT(3), .CNT_W(4)) u_dut3 (
    .clk(clk), .rst(rst3),
    .req0_valid(v0_3), .req0_addr(a0_3), .req0_ready(rdy0_3),
    .rsp0_valid(rv0_3), .rsp0_data(rd0_3),
    .req1_valid(v1_3), .req1_addr(a1_3), .req1_ready(rdy1_3),
    .rsp1_valid(rv1_3), .rsp1_data(rd1_3),
    .mem_addr(ma_3), .mem_rdata(mr_3), .gnt0_count(c0_3), .gnt1_count(c1_3)
  );

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {~a, a};
  endfunction

  // Program memories: data appears MEM_LAT edges after the address changes.
  always @(posedge clk) begin
    mr_1  <= mem_word(ma_1);
    m2_p0 <= mem_word(ma_2);
    mr_2  <= m2_p0;
    m3_p0 <= mem_word(ma_3);
    m3_p1 <= m3_p0;
    mr_3  <= m3_p1;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    {v0_1, v1_1, v0_2, v1_2, v0_3, v1_3} = '0;
    {a0_1, a1_1, a0_2, a1_2, a0_3, a1_3} = '0;
    rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;

    // Reset: ready stays low even with both requesters valid
    step();
    v0_1 = 1'b1; v1_1 = 1'b1;
    @(negedge clk);
    check("rst_ready0", 32'(rdy0_1), 32'd0);
    check("rst_ready1", 32'(rdy1_1), 32'd0);
    step();
    check("rst_mem_addr", 32'(ma_1), 32'h0);
    check("rst_cnt0", 32'(c0_1), 32'd0);
    check("rst_cnt1", 32'(c1_1), 32'd0);
    check("rst_rsp_valid", 32'({rv0_1, rv1_1}), 32'd0);
    rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
    v0_1 = 1'b0; v1_1 = 1'b0;

    // Single request on requester 0
    v0_1 = 1'b1; a0_1 = 16'h0010;
    @(negedge clk);
    check("single_ready0", 32'(rdy0_1), 32'd1);
    check("single_ready1", 32'(rdy1_1), 32'd0);
    step();
    v0_1 = 1'b0;
    check("single_mem_addr", 32'(ma_1), 32'h0010);
    check("single_rsp_early", 32'(rv0_1), 32'd0);
    check("single_cnt0", 32'(c0_1), 32'd1);
    step();
    check("single_rsp_valid", 32'(rv0_1), 32'd1);
    check("single_rsp_data", rd0_1, mem_word(16'h0010));
    step();
    check("single_rsp_drop", 32'(rv0_1), 32'd0);
    check("single_rsp_zero", rd0_1, 32'h0);

    // Contention after a fresh reset: grants 0,1,0,1
    rst1 = 1'b1;
    step();
    rst1 = 1'b0;
    v0_1 = 1'b1; a0_1 = 16'h0000;
    v1_1 = 1'b1; a1_1 = 16'h0080;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("cont_ready0", 32'(rdy0_1), 32'(k % 2 == 0));
      check("cont_ready1", 32'(rdy1_1), 32'(k % 2 == 1));
      step();
      check("cont_mem_addr", 32'(ma_1), (k % 2 == 0) ? 32'h0000 : 32'h0080);
      check("cont_rsp0", 32'(rv0_1), 32'(k >= 1 && (k - 1) % 2 == 0));
      check("cont_rsp1", 32'(rv1_1), 32'(k >= 1 && (k - 1) % 2 == 1));
    end
    v0_1 = 1'b0; v1_1 = 1'b0;
    step();
    check("cont_last_rsp1", 32'(rv1_1), 32'd1);
    check("cont_last_data", rd1_1, mem_word(16'h0080));
    check("cont_cnt0", 32'(c0_1), 32'd2);
    check("cont_cnt1", 32'(c1_1), 32'd2);

    // Top-of-range address passes through unchanged
    v1_1 = 1'b1; a1_1 = 16'hFFFF;
    step();
    v1_1 = 1'b0;
    check("ffff_mem_addr", 32'(ma_1), 32'h0000FFFF);
    step();
    check("ffff_rsp_data", rd1_1, mem_word(16'hFFFF));

    // Idle hold
    v0_1 = 1'b1; a0_1 = 16'h1234;
    step();
    v0_1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("idle_mem_addr", 32'(ma_1), 32'h1234);
      check("idle_rsp0", 32'(rv0_1), 32'(i == 1));
      check("idle_rsp1", 32'(rv1_1), 32'd0);
      step();
    end

    // MEM_LAT=3: three back-to-back accepts on requester 1
    v1_3 = 1'b1; a1_3 = 16'h0100;
    for (int c = 0; c < 8; c++) begin
      step();
      if (c < 2) a1_3 = 16'(16'h0101 + c);
      else       v1_3 = 1'b0;
      check("lat3_rsp1_valid", 32'(rv1_3), 32'(c >= 3 && c <= 5));
      check("lat3_rsp1_data", rd1_3,
            (c >= 3 && c <= 5) ? mem_word(16'(16'h0100 + c - 3)) : 32'h0);
      check("lat3_rsp0", 32'(rv0_3), 32'd0);
    end
    check("lat3_cnt1", 32'(c1_3), 32'd3);

    // Saturation of a 4-bit counter
    v1_3 = 1'b1;
    repeat (11) step();
    check("sat_cnt_14", 32'(c1_3), 32'd14);
    step();
    check("sat_cnt_15", 32'(c1_3), 32'd15);
    repeat (8) step();
    v1_3 = 1'b0;
    check("sat_cnt_hold", 32'(c1_3), 32'd15);

    // MEM_LAT=2: reset one edge after an accept kills the response
    v0_2 = 1'b1; a0_2 = 16'h0042;
    step();
    v0_2 = 1'b0; rst2 = 1'b1;
    check("rmid_mem_addr_pre", 32'(ma_2), 32'h0042);
    check("rmid_rsp_in_rst", 32'(rv0_2), 32'd0);
    step();
    rst2 = 1'b0;
    check("rmid_mem_addr", 32'(ma_2), 32'h0);
    check("rmid_cnt0", 32'(c0_2), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("rmid_no_rsp0", 32'(rv0_2), 32'd0);
      step();
    end
    v0_2 = 1'b1; a0_2 = 16'h0050;
    v1_2 = 1'b1; a1_2 = 16'h0060;
    @(negedge clk);
    check("rmid_cont_ready0", 32'(rdy0_2), 32'd1);
    check("rmid_cont_ready1", 32'(rdy1_2), 32'd0);
    step();
    v0_2 = 1'b0; v1_2 = 1'b0;
    check("rmid_cont_addr", 32'(ma_2), 32'h0050);
    check("rmid_cont_cnt0", 32'(c0_2), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/program_port_arbiter.md
PROGRAM_PORT_ARBITER -- requirements
Module: program_port_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1, meaning clock edges from a mem_addr update to valid mem_rdata; legal range 1..4.
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of each per-requester grant counter.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have ports req0_valid  input  1, req0_addr  input  16, req0_ready  output  1; requester 0 (instruction fetch) read request.
REQ-006 SHALL have ports rsp0_valid  output  1, rsp0_data  output  32; requester 0 response, byte at addr in bits [7:0], addr+3 in [31:24].
REQ-007 SHALL have ports req1_valid, req1_addr, req1_ready, rsp1_valid, rsp1_data with the same directions, widths and meanings for requester 1 (data load).
REQ-008 SHALL have port mem_addr  output  16  address to the shared program memory.
REQ-009 SHALL have port mem_rdata  input  32  memory read data, four bytes concatenated {out3,out2,out1,out0}.
REQ-010 SHALL have ports gnt0_count, gnt1_count  output  CNT_W  accepted-request counters.

Function
REQ-011 SHALL accept a request on a rising edge E when reqN_valid and reqN_ready are both high.
REQ-012 SHALL grant at most one requester per cycle; reqN_ready is combinational from the valids and arbitration state.
REQ-013 SHALL grant the only valid requester when exactly one is valid, and neither when none is.
REQ-014 SHALL, when both are valid, grant the requester not granted most recently (round-robin).
REQ-015 SHALL update the last-granted state only on an accepted request.
REQ-016 SHALL register the granted address into mem_addr at edge E; mem_addr SHALL hold its value when no request is accepted.
REQ-017 SHALL assert rspN_valid for exactly one cycle, the cycle starting at edge E+MEM_LAT, for the requester accepted at E, with rspN_data equal to mem_rdata in that cycle.
REQ-018 SHALL keep the response pipeline fully pipelined: back-to-back accepts return back-to-back responses, in issue order, each routed by a tag carried through the pipeline.
REQ-019 SHALL have no response backpressure; requesters must consume rspN_valid when asserted.
REQ-020 SHALL hold rspN_data at 0 whenever rspN_valid is low.
REQ-021 SHALL pass addresses through unmodified; 16'hFFFF is legal, and memory-side wrap of addr+1..3 is not the arbiter's concern.
REQ-022 SHALL increment gntN_count on each accept by N, saturating at all-ones.

Reset
REQ-023 SHALL, on rst high at a rising edge, set mem_addr=0, gnt0_count=0, gnt1_count=0, and last-granted=1 so that requester 0 wins the first contention.
REQ-024 SHALL clear all in-flight tags on reset; responses for requests accepted before reset SHALL never be asserted.
REQ-025 SHALL hold req0_ready, req1_ready, rsp0_valid and rsp1_valid low during any cycle in which rst is high.

Structure
REQ-026 SHALL take the requester-id type (1 bit), the MEM_LAT default and the response-tag struct (valid, id) from shared package program_port_pkg.
REQ-027 SHALL instantiate one sub-module, rr_arbiter2: two-way round-robin grant with last-granted state.

Verification
REQ-028 Single request: after reset, req0 addr 0x0010 valid for 1 cycle -> ready high, mem_addr=0x0010 next cycle, rsp0_valid one cycle at E+1 with data=mem_rdata, gnt0_count=1.
REQ-029 Contention: both valid for 4 cycles (req0 0x0000, req1 0x0080) -> grants 0,1,0,1; responses alternate rsp0/rsp1 at E+1..E+4; both counts=2.
REQ-030 Latency sweep: MEM_LAT=3, req1 accepts at three consecutive edges -> three consecutive rsp1_valid pulses starting 3 edges after the first accept, in order.
REQ-031 Idle hold: accept 0x1234 then 5 idle cycles -> mem_addr stays 0x1234, no rsp valid after the single response.
REQ-032 Reset mid-flight: MEM_LAT=2, accept req0 at E, rst at E+1 -> no rsp0_valid ever, mem_addr=0, counts=0, next contention grants req0.
REQ-033 Saturation: CNT_W=4, 20 accepts on req1 -> gnt1_count stops at 15.
